instr_sequencer: RTL

//  Multi-cycle instruction sequencer for the tau datapath.
//  - Steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
//  - Drives the PC, IR, memory, ALU and register-file strobes per state and 4-bit opcode.
//  - Handshakes with memory via mem_ready; counts retired instructions.
//  - Sits between the memory interface and the datapath; replaces the single-cycle opcode decode.

---
 rtl/instr_sequencer_if.sv | 31 +++
 rtl/instr_sequencer.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/instr_sequencer_if.sv
// Bus between the instruction sequencer and the memory/datapath it controls.
// The master modport is the sequencer; the slave modport is the surrounding datapath.
interface instr_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             run;
  logic [3:0]       opcode;
  logic             mem_ready;
  logic [3:0]       alu_op;
  logic             pc_load;
  logic             pc_inc;
  logic             ir_load;
  logic             mem_read;
  logic             mem_write;
  logic             reg_write;
  logic [2:0]       state;
  logic             err;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  run, opcode, mem_ready,
    output alu_op, pc_load, pc_inc, ir_load, mem_read, mem_write, reg_write,
           state, err, instr_count
  );

  modport slave (
    output run, opcode, mem_ready,
    input  alu_op, pc_load, pc_inc, ir_load, mem_read, mem_write, reg_write,
           state, err, instr_count
  );
endinterface

// File: rtl/instr_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the tau datapath.
// Define SEQ_HALT_EN to make opcode 1111 retire into a terminal HALT state.
module instr_sequencer #(
  parameter int WAIT_MAX = 16,
  parameter int CNT_W    = 16
) (
  input logic               clk,
  input logic               rst,
  instr_sequencer_if.master bus
);
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_ERR    = 3'd7
  } state_t;

  localparam logic [3:0] OP_LOAD  = 4'h0;
  localparam logic [3:0] OP_STORE = 4'h1;
  localparam logic [3:0] OP_JMP   = 4'hE;
  localparam int WW = $clog2(WAIT_MAX + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_MAX - 1);

  state_t           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [WW-1:0]    wait_q, wait_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             is_mem_op;
  logic             is_halt_op;
  state_t           retire_state;

  assign is_mem_op    = (op_q == OP_LOAD) || (op_q == OP_STORE);
`ifdef SEQ_HALT_EN
  assign is_halt_op   = (op_q == 4'hF);
`else
  assign is_halt_op   = 1'b0;
`endif
  assign retire_state = bus.run ? S_FETCH : S_IDLE;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    wait_d  = wait_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: if (bus.run) state_d = S_FETCH;
      S_FETCH, S_MEM: begin
        if (bus.mem_ready) begin
          wait_d = '0;
          if (state_q == S_FETCH) begin
            state_d = S_DECODE;
          end else if (op_q == OP_LOAD) begin
            state_d = S_WB;
          end else begin
            state_d = retire_state;
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end else if (wait_q == WAIT_LAST) begin
          // This low cycle is the WAIT_MAX-th in a row: give up on the access.
          state_d = S_ERR;
          err_d   = 1'b1;
          wait_d  = '0;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      S_DECODE: begin
        op_d    = bus.opcode;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (is_mem_op) begin
          state_d = S_MEM;
        end else if (op_q == OP_JMP) begin
          state_d = retire_state;
          cnt_d   = cnt_q + CNT_W'(1);
        end else if (is_halt_op) begin
          state_d = S_HALT;
          cnt_d   = cnt_q + CNT_W'(1);
        end else begin
          state_d = S_WB;
        end
      end
      S_WB: begin
        state_d = retire_state;
        cnt_d   = cnt_q + CNT_W'(1);
      end
      default: ; // HALT and ERR are left only through reset
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      wait_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      wait_q  <= wait_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Strobes decode from the current state; ir_load/pc_inc also follow mem_ready.
  always_comb begin
    bus.alu_op    = 4'h0;
    bus.pc_load   = 1'b0;
    bus.pc_inc    = 1'b0;
    bus.ir_load   = 1'b0;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.reg_write = 1'b0;
    case (state_q)
      S_FETCH: begin
        bus.mem_read = 1'b1;
        if (bus.mem_ready) begin
          bus.ir_load = 1'b1;
          bus.pc_inc  = 1'b1;
        end
      end
      S_EXEC: begin
        if (op_q == OP_JMP)               bus.pc_load = 1'b1;
        else if (!is_mem_op && !is_halt_op) bus.alu_op = op_q;
      end
      S_MEM: begin
        if (op_q == OP_LOAD) bus.mem_read  = 1'b1;
        else                 bus.mem_write = 1'b1;
      end
      S_WB:    bus.reg_write = 1'b1;
      default: ;
    endcase
  end

  assign bus.state       = state_q;
  assign bus.err         = err_q;
  assign bus.instr_count = cnt_q;
endmodule
